// File: rtl/shift_rx.sv
// Serial-to-parallel receiver: rebuilds LSB-first words framed by eos.
// Ports: clk, rst, sin, eos, dout_ready in; dout, dout_valid, frame_err, ovf out.
module shift_rx #(
   parameter int bits = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sin,
   input  logic            eos,
   output logic [bits-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            frame_err,
   output logic            ovf
);

   localparam int CW = $clog2(bits + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(bits);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q;
   logic [bits-1:0]   sreg_q;
   logic [bits-1:0]   sreg_d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic [bits-1:0]   dout_q;
   logic              ferr_q;
   logic              ovf_q;
   logic              good;
   logic              push;
   logic              pop;

   assign good = (cnt_q == FULL_CNT);
   assign push = eos & good;
   assign pop  = (state_q == FULL) & dout_ready;

   // Collect path; eos freezes the shifter and rearms the counter.
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (eos) begin
         cnt_d = '0;
      end else begin
         sreg_d = {sin, sreg_q[bits-1:1]};
         if (!good) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         sreg_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
         ferr_q <= eos & ~good;
         unique case (state_q)
            EMPTY: begin
               if (push) begin
                  dout_q  <= sreg_q;
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (push && pop) begin
                  dout_q <= sreg_q;
               end else if (pop) begin
                  state_q <= EMPTY;
               end else if (push) begin
                  // Word arrives with nowhere to go; it is lost.
                  ovf_q <= 1'b1;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_valid = (state_q == FULL);
   assign frame_err  = ferr_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_shift_rx.sv
// Self-checking bench for shift_rx with a queue of expected words.
// Drives frames, short frames, backpressure and mid-frame reset.
module tb_shift_rx;

   localparam int B = 6;

   logic         clk;
   logic         rst;
   logic         sin;
   logic         eos;
   logic [B-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         frame_err;
   logic         ovf;

   int n_cmp;
   int n_err;
   logic [B-1:0] exp_q[$];
   logic [B-1:0] exp_w;

   shift_rx #(.bits(B)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .eos        (eos),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sin = 1'b0;
      eos = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic send_bits(input logic [31:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         sin = d[i];
         eos = 1'b0;
         cyc();
      end
      sin = 1'b0;
   endtask

   task automatic send_eos();
      eos = 1'b1;
      sin = 1'b1;
      cyc();
      eos = 1'b0;
      sin = 1'b0;
   endtask

   task automatic frame(input logic [B-1:0] w, input bit acc);
      send_bits(32'(w), B);
      if (acc) exp_q.push_back(w);
      send_eos();
   endtask

   task automatic pop_exp();
      if (exp_q.size() == 0) exp_w = 'x;
      else exp_w = exp_q.pop_front();
   endtask

   task automatic test_reset();
      dout_ready = 1'b1;
      do_reset();
      n_cmp++;
      if (dout !== '0) begin
         n_err++;
         $display("FAIL rst_dout got %h want 00", dout);
      end
      n_cmp++;
      if (dout_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_valid got %b want 0", dout_valid);
      end
      n_cmp++;
      if (frame_err !== 1'b0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL rst_status got %b%b want 00", frame_err, ovf);
      end
   endtask

   task automatic test_basic();
      dout_ready = 1'b1;
      frame(6'h2D, 1'b1);
      pop_exp();
      n_cmp++;
      if (dout_valid !== 1'b1 || dout !== exp_w) begin
         n_err++;
         $display("FAIL basic_word got %b/%h want 1/%h", dout_valid, dout, exp_w);
      end
      cyc();
      n_cmp++;
      if (dout_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_pop got %b want 0", dout_valid);
      end
      n_cmp++;
      if (frame_err !== 1'b0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL basic_status got %b%b want 00", frame_err, ovf);
      end
   endtask

   task automatic test_long();
      do_reset();
      dout_ready = 1'b1;
      send_bits(32'h0, 1);
      frame(6'h2D, 1'b1);
      pop_exp();
      n_cmp++;
      if (dout_valid !== 1'b1 || dout !== exp_w || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL long_word got %b/%h/%b want 1/%h/0", dout_valid, dout, frame_err, exp_w);
      end
   endtask

   task automatic test_short();
      do_reset();
      dout_ready = 1'b1;
      frame(6'h2D, 1'b1);
      pop_exp();
      n_cmp++;
      if (dout !== exp_w) begin
         n_err++;
         $display("FAIL short_pre got %h want %h", dout, exp_w);
      end
      send_bits(32'hA, 4);
      send_eos();
      n_cmp++;
      if (frame_err !== 1'b1) begin
         n_err++;
         $display("FAIL short_ferr got %b want 1", frame_err);
      end
      n_cmp++;
      if (dout_valid !== 1'b0 || dout !== 6'h2D) begin
         n_err++;
         $display("FAIL short_hold got %b/%h want 0/2d", dout_valid, dout);
      end
      send_bits(32'h12, 1);
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL short_pulse got %b want 0", frame_err);
      end
      send_bits(32'h12 >> 1, B - 1);
      exp_q.push_back(6'h12);
      send_eos();
      pop_exp();
      n_cmp++;
      if (dout_valid !== 1'b1 || dout !== exp_w) begin
         n_err++;
         $display("FAIL short_next got %b/%h want 1/%h", dout_valid, dout, exp_w);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dout_ready = 1'b1;
      send_bits(32'h5, 3);
      send_eos();
      n_cmp++;
      if (frame_err !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_first got %b want 1", frame_err);
      end
      send_bits(32'h3, 1);
      n_cmp++;
      if (frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_gap got %b want 0", frame_err);
      end
      send_bits(32'h1, 1);
      send_eos();
      n_cmp++;
      if (frame_err !== 1'b1 || dout_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_second got %b/%b want 1/0", frame_err, dout_valid);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      dout_ready = 1'b0;
      frame(6'h2D, 1'b1);
      pop_exp();
      n_cmp++;
      if (dout_valid !== 1'b1 || dout !== exp_w) begin
         n_err++;
         $display("FAIL bp_first got %b/%h want 1/%h", dout_valid, dout, exp_w);
      end
      frame(6'h12, 1'b0);
      n_cmp++;
      if (dout !== 6'h2D || dout_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold got %b/%h want 1/2d", dout_valid, dout);
      end
      n_cmp++;
      if (ovf !== 1'b1) begin
         n_err++;
         $display("FAIL bp_ovf got %b want 1", ovf);
      end
      dout_ready = 1'b1;
      cyc();
      n_cmp++;
      if (dout_valid !== 1'b0 || ovf !== 1'b1) begin
         n_err++;
         $display("FAIL bp_drain got %b/%b want 0/1", dout_valid, ovf);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_queue got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_simul();
      do_reset();
      dout_ready = 1'b0;
      frame(6'h2D, 1'b1);
      pop_exp();
      n_cmp++;
      if (dout !== exp_w) begin
         n_err++;
         $display("FAIL sim_first got %h want %h", dout, exp_w);
      end
      send_bits(32'h12, B);
      dout_ready = 1'b1;
      exp_q.push_back(6'h12);
      send_eos();
      dout_ready = 1'b0;
      pop_exp();
      n_cmp++;
      if (dout !== exp_w || dout_valid !== 1'b1) begin
         n_err++;
         $display("FAIL sim_swap got %b/%h want 1/%h", dout_valid, dout, exp_w);
      end
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_err++;
         $display("FAIL sim_ovf got %b want 0", ovf);
      end
   endtask

   task automatic test_rst_mid();
      dout_ready = 1'b0;
      frame(6'h21, 1'b0);
      send_bits(32'h7, 3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      n_cmp++;
      if (dout !== '0 || dout_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_out got %b/%h want 0/00", dout_valid, dout);
      end
      n_cmp++;
      if (frame_err !== 1'b0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL mid_status got %b%b want 00", frame_err, ovf);
      end
      dout_ready = 1'b1;
      frame(6'h3F, 1'b1);
      pop_exp();
      n_cmp++;
      if (dout !== exp_w || dout_valid !== 1'b1 || frame_err !== 1'b0) begin
         n_err++;
         $display("FAIL mid_word got %b/%h/%b want 1/%h/0", dout_valid, dout, frame_err, exp_w);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      sin = 1'b0;
      eos = 1'b0;
      dout_ready = 1'b0;
      test_reset();
      test_basic();
      test_long();
      test_short();
      test_back_to_back();
      test_backpressure();
      test_simul();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_rx.md
# shift_rx

Serial-to-parallel receiver that sits directly downstream of the team's parallel-to-serial shifter. It consumes the shifter's serial bit stream (`sin`, LSB first) and end-of-shift strobe (`eos`), and rebuilds each `bits`-wide word. Each good word is presented on a one-entry output register with a valid/ready handshake. Short frames and dropped words are reported on status outputs.

## Interface
- `bits`, default 6: word width. Must match the upstream shifter. Legal range is ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial data, one bit per cycle, LSB first.
- `eos`  in  1  end-of-frame strobe, 1 cycle. `sin` is ignored in the `eos` cycle.
- `dout`  out  `bits`  received word.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` on any edge where `dout_valid`=1 and `dout_ready`=1.
- `frame_err`  out  1  one-cycle pulse: frame ended with fewer than `bits` data bits.
- `ovf`  out  1  sticky: a good word was dropped because the output register was full.

## Operation
- Upstream frame format:
  - `bits` data cycles with `eos`=0, carrying D[0]..D[bits-1].
  - One cycle with `eos`=1, value on `sin` don't-care.
  - Next frame follows immediately. Period is `bits`+1 cycles.
- Collect path:
  - `sreg[bits-1:0]`: on each edge with `eos`=0, `sreg <= {sin, sreg[bits-1:1]}`.
  - `cnt`, width clog2(`bits`+1): increments on each edge with `eos`=0 and saturates at `bits`.
  - After `bits` shifts, `sreg[0]` holds the first bit of the frame.
- Long frames (more than `bits` data cycles, e.g. one stale bit right after a common reset) are accepted. The oldest extra bits shift out; the last `bits` samples before `eos` form the word. No error is raised.
- End of frame (edge with `eos`=1):
  - `cnt` <= 0 and `sreg` is not shifted.
  - `cnt` == `bits` gives a good frame. `cnt` < `bits` gives a short frame: `frame_err`=1 for the next cycle, the word is discarded, and the output register is untouched.
- Output register, two states:
  - EMPTY (`dout_valid`=0).
  - FULL (`dout_valid`=1).
- Transitions on each edge, where pop = FULL & `dout_ready`, and push = good frame end:
  - EMPTY, push: load `dout` <= `sreg`, go to FULL.
  - FULL, pop, no push: go to EMPTY. `dout` keeps its last value.
  - FULL, pop and push together: load new word, stay FULL. No loss and no `ovf`.
  - FULL, push, no pop: drop the new word, `ovf` <= 1. `dout` is unchanged.
  - Short frame while FULL: `frame_err` only; `ovf` does not change.
- `dout` never changes while FULL unless pop is true on the same edge.
- `ovf` clears only on `rst`.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `frame_err`=0, `ovf`=0. Internally `sreg`=0 and `cnt`=0.
- `rst` overrides every other input on the same edge. `rst` mid-frame discards partial bits, and collection restarts from `cnt`=0 on the first edge after `rst` falls.
- Latency: `eos` sampled at edge N gives `dout`/`dout_valid` updated after edge N, i.e. 1 cycle after the `eos` cycle. The same holds for `frame_err`.
- Throughput: one word per `bits`+1 cycles. The handshake never stalls `sin`; the block cannot backpressure upstream.
- `frame_err` is a 1-cycle pulse. Back-to-back short frames give separate pulses.
- Registered outputs only; no combinational path from inputs to outputs.

## Test plan
- Basic word: `bits`=6, `dout_ready`=1, send 1,0,1,1,0,1 then `eos` → `dout`=6'h2D with `dout_valid`=1 for 1 cycle, then 0. `frame_err`=0, `ovf`=0.
- Common reset with extra leading bit: send 0,1,0,1,1,0,1 then `eos` → `dout`=6'h2D, `frame_err`=0.
- Short frame: send 4 bits then `eos` → `frame_err`=1 for exactly 1 cycle, `dout_valid` stays 0, and `dout` stays at its prior value. Next frame 0,1,0,0,1,0 → `dout`=6'h12.
- Backpressure: `dout_ready`=0, send 6'h2D then 6'h12 → `dout`=6'h2D held and `ovf`=1 after the second `eos`. Raise `dout_ready` → `dout_valid` falls next edge; `ovf` stays 1.
- Simultaneous pop/push: FULL with 6'h2D, `dout_ready`=1 in the `eos` cycle of 6'h12 → `dout`=6'h12, `dout_valid` stays 1, `ovf`=0.
- Reset mid-frame: 3 bits in, assert `rst` 1 cycle → all outputs 0. Then a full frame 6'h3F → `dout`=6'h3F, no error.
